preamp_debounce: RTL and testbench

- Upstream partner of the preamp oneshot stage.
- Takes a raw, bouncy, asynchronous push-button level (e.g. the get_rdid button) and produces a clean, clock-synchronous debounced level (get_rdid_debounce) for the oneshot/SPI command path.
- Also emits single-cycle rise/fall strobes so consumers can bypass the separate oneshot if needed.

---
 rtl/preamp_pkg.sv | 16 +
 rtl/preamp_sync2.sv | 23 ++
 rtl/preamp_debounce.sv | 98 +++++++++
 tb/tb_preamp_debounce.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/preamp_pkg.sv
// Shared definitions for the preamp button path: debounce FSM state
// encoding and default timing constants.
package preamp_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        LOW_PEND    = 2'd1,
        HIGH_STABLE = 2'd2,
        HIGH_PEND   = 2'd3
    } state_t;

    // 10 ms of stable input at the nominal 50 MHz system clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int CLK_HZ                  = 50_000_000;

endpackage

// File: rtl/preamp_sync2.sv
// Two-flop synchronizer for asynchronous button levels. Resets to 0 so a
// held button after reset is seen as a fresh press downstream.
module preamp_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // Metastability chain: s1 may go metastable, q is the settled copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/preamp_debounce.sv
// Push-button debouncer: synchronizes the raw level, then requires
// DEBOUNCE_CYCLES consecutive identical samples before the clean level
// flips. Emits one-cycle rise/fall strobes alongside the level change.
module preamp_debounce
    import preamp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_debounce,
    output logic btn_rise,
    output logic btn_fall
);

    // Counter value on the sample that completes qualification.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic             s2;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rise_n, fall_n;

    preamp_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (s2)
    );

    // State, counter and strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= LOW_STABLE;
            cnt      <= '0;
            btn_rise <= 1'b0;
            btn_fall <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            btn_rise <= rise_n;
            btn_fall <= fall_n;
        end
    end

    // Next-state logic. cnt holds the number of consecutive samples seen
    // at the new level; any reversion drops back to the stable state at 0.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            LOW_STABLE: begin
                if (s2) begin
                    state_n = LOW_PEND;
                    cnt_n   = ONE;
                end
            end
            LOW_PEND: begin
                if (!s2) begin
                    state_n = LOW_STABLE;
                end else if (cnt == LAST) begin
                    state_n = HIGH_STABLE;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            HIGH_STABLE: begin
                if (!s2) begin
                    state_n = HIGH_PEND;
                    cnt_n   = ONE;
                end
            end
            HIGH_PEND: begin
                if (s2) begin
                    state_n = HIGH_STABLE;
                end else if (cnt == LAST) begin
                    state_n = LOW_STABLE;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = LOW_STABLE;
            end
        endcase
    end

    // Output is high in both HIGH states: a pending release keeps it high.
    assign btn_debounce = (state == HIGH_STABLE) || (state == HIGH_PEND);

endmodule

// File: tb/tb_preamp_debounce.sv
// Directed bench for preamp_debounce with DEBOUNCE_CYCLES=4.
module tb_preamp_debounce;
    import preamp_pkg::*;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_debounce, btn_rise, btn_fall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic raw;
        logic deb;
        logic rise;
        logic fall;
    } vec_t;

    vec_t vecs[$];

    preamp_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_debounce (btn_debounce),
        .btn_rise     (btn_rise),
        .btn_fall     (btn_fall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert (!(btn_rise && btn_fall)) else $error("rise and fall together");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic d, input logic r, input logic f);
        chk({name, "_deb"},  {31'd0, btn_debounce}, {31'd0, d});
        chk({name, "_rise"}, {31'd0, btn_rise},     {31'd0, r});
        chk({name, "_fall"}, {31'd0, btn_fall},     {31'd0, f});
    endtask

    task automatic add(input logic r, input int n, input logic d, input logic ri, input logic f);
        vec_t v;
        v.raw = r; v.deb = d; v.rise = ri; v.fall = f;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // Test 1: reset held with button pressed, then release.
        btn_raw = 1'b1;
        rst     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("rst_hold%0d", i), 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_out($sformatf("pwrup_e%0d", i), (i >= 6), (i == 6), 1'b0);
        end

        // Test 6: long stable high.
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk_out($sformatf("hold_hi%0d", i), 1'b1, 1'b0, 1'b0);
            chk($sformatf("hold_hi_cnt%0d", i), {29'd0, dut.cnt}, 32'd0);
        end

        // Test 5: reset while in HIGH_PEND after 3 low samples.
        btn_raw = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_out($sformatf("pend_e%0d", i), 1'b1, 1'b0, 1'b0);
        end
        chk("pend_state", {30'd0, dut.state}, {30'd0, HIGH_PEND});
        chk("pend_cnt", {29'd0, dut.cnt}, 32'd3);
        #1 rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 1'b0, 1'b0);
        chk("async_rst_state", {30'd0, dut.state}, {30'd0, LOW_STABLE});
        chk("async_rst_cnt", {29'd0, dut.cnt}, 32'd0);
        tick();
        tick();
        chk_out("rst_low", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out($sformatf("post_rst%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Tests 2-4 as a per-edge table: raw driven before the edge,
        // outputs expected just after it. FSM sees raw two edges late.
        add(1'b0, 3, 1'b0, 1'b0, 1'b0);
        // Clean press: qualifies on the 6th edge of the press.
        add(1'b1, 5, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3, 1'b1, 1'b0, 1'b0);
        // Clean release.
        add(1'b0, 5, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 3, 1'b0, 1'b0, 1'b0);
        // Bounce 1,0,1,0 every 2 cycles, then hold 1.
        add(1'b1, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b1, 2, 1'b0, 1'b0, 1'b0);
        add(1'b0, 2, 1'b0, 1'b0, 1'b0);
        add(1'b1, 5, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 3, 1'b1, 1'b0, 1'b0);
        // Release back to low.
        add(1'b0, 5, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 3, 1'b0, 1'b0, 1'b0);
        // Single-cycle glitch.
        add(1'b1, 1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 7, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            btn_raw = vecs[i].raw;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].deb, vecs[i].rise, vecs[i].fall);
        end
        chk("glitch_state", {30'd0, dut.state}, {30'd0, LOW_STABLE});
        chk("glitch_cnt", {29'd0, dut.cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
